uart_rx_deser: RTL and testbench
================================

// Module: uart_rx_deser
// PURPOSE
//  Async serial receiver in front of the uart1 Wishbone CSR. 8N1, LSB first, 19200 baud off the 48 MHz ref_clk.
//  Synchronises the Feather RX pin, deserialises each frame and buffers the bytes.
//  Presents bytes on a valid/ready pop port that uart1 drains on Wishbone reads.
//  irq_o feeds the top-level RX interrupt.
// PARAMETERS
//  CLK_HZ      48_000_000  input clock frequency
//  BAUD        19_200      line rate; localparam CLKS_PER_BIT = CLK_HZ/BAUD (2500), HALF_BIT = CLKS_PER_BIT/2 (1250)
//  FIFO_DEPTH  8           byte buffer depth, power of 2, >=2 (used only with UART_RX_FIFO_EN)
// PORTS
//  clk_48_i     in   1   system clock, 48 MHz
//  rst_ni       in   1   reset, asynchronous, active-low
//  rx_i         in   1   raw serial line (idle high), asynchronous to clk_48_i
//  dat_o        out  8   head byte; first-word-fall-through; valid only when valid_o=1
//  valid_o      out  1   buffer non-empty
//  ready_i      in   1   pop; a byte is consumed on a cycle with valid_o & ready_i
//  irq_o        out  1   level interrupt, equals valid_o
//  count_o      out  4   bytes currently buffered (0..FIFO_DEPTH)
//  frame_err_o  out  1   sticky: stop bit sampled low
//  overrun_o    out  1   sticky: byte dropped because buffer was full
//  clr_err_i    in   1   one-cycle pulse; clears both sticky flags
// BEHAVIOUR
//  Reset (rst_ni=0, async): FSM=IDLE, sync flops=1, buffer empty.
//   dat_o=0, valid_o=0, irq_o=0, count_o=0, frame_err_o=0, overrun_o=0.
//  Sync: 2-FF synchroniser on rx_i (reset to 1); all sampling uses the 2nd flop (rx_s).
//  FSM states: IDLE, START, DATA, STOP, WAIT_HI; bit-timer cnt 0..CLKS_PER_BIT-1; bit index 0..7.
//   IDLE:    rx_s=0 -> START, cnt=0.
//   START:   at cnt=HALF_BIT-1 sample rx_s.
//            1 -> IDLE (glitch rejected, no flag).
//            0 -> DATA, cnt=0, idx=0.
//   DATA:    at cnt=CLKS_PER_BIT-1 shift rx_s into bit idx (LSB first); cnt=0.
//            After idx=7 -> STOP.
//   STOP:    at cnt=CLKS_PER_BIT-1 sample rx_s.
//            1 -> push byte, IDLE.
//            0 -> set frame_err_o, discard byte, WAIT_HI.
//   WAIT_HI: stay until rx_s=1, then IDLE (a break condition yields exactly one frame_err).
//  Timing: push occurs in the stop-bit sample cycle; valid_o rises the next cycle.
//   This is 2 sync cycles + 9.5 bit times (~23752 clk) after the start-bit falling edge.
//  Push when full: byte dropped, overrun_o set, buffer contents unchanged.
//   Exception: a pop in the same cycle frees a slot, so the push is accepted and count_o is unchanged.
//  Pop when empty: ignored.
//  clr_err_i in the same cycle as a new error event: the set wins.
//  Widths: count_o is $clog2(FIFO_DEPTH)+1 bits, zero-extended to 4.
//   Rd/wr pointers wrap modulo FIFO_DEPTH.
//  Reset asserted mid-frame: the partial byte is lost; reception resumes at the next falling edge after release.
// CONFIGURATION
//  `UART_RX_FIFO_EN defined: FIFO_DEPTH-entry circular buffer as above.
//  Not defined: single holding register (effective depth 1, count_o 0..1).
//   A second byte arriving before the pop sets overrun_o and is dropped.
//   FIFO_DEPTH is ignored.
// STRUCTURE
//  Package uart_pkg:
//   - rx_state_e enum (one-hot: IDLE, START, DATA, STOP, WAIT_HI)
//   - function clks_per_bit(CLK_HZ, BAUD)
//   - BYTE_W=8
//  Sub-module byte_fifo (FWFT, push/pop/full/empty/count) is instantiated only under `UART_RX_FIFO_EN.
//  Sampler FSM and error flags stay in uart_rx_deser.
// TESTING
//  1. Drive 0x41 at 2500 clk/bit, ready_i=0.
//     -> valid_o=1, dat_o=0x41, count_o=1 at 23752+-2 clk after the falling edge.
//     -> Pulse ready_i: count_o=0.
//  2. Drive rx_i low for 500 clk, then high.
//     -> FSM back to IDLE, valid_o stays 0, no flags.
//  3. Frame 0x55 with stop bit low, then line high.
//     -> frame_err_o=1, count_o=0. clr_err_i pulse -> frame_err_o=0.
//  4. FIFO_EN: send 0x30..0x38 (9 bytes), ready_i=0.
//     -> count_o=8, overrun_o=1, pops return 0x30..0x37 in order.
//  5. Full buffer with ready_i=1 held while byte 0x39 arrives.
//     -> accepted, count_o stays 8, last pop yields 0x39.
//  6. Assert rst_ni for 3 clk mid-DATA of 0x7E, then send 0x12.
//     -> all outputs reset, only 0x12 received.
//     Without `UART_RX_FIFO_EN: 2 unpopped bytes -> overrun_o=1, dat_o=first byte.

Source files
------------

// File: rtl/uart_rx_deser_pkg.sv
// uart_pkg: shared types and helpers for the uart1 serial receiver.
//   rx_state_e   - one-hot sampler FSM state
//   clks_per_bit - ref clocks per serial bit
//   BYTE_W       - payload width
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        START   = 5'b00010,
        DATA    = 5'b00100,
        STOP    = 5'b01000,
        WAIT_HI = 5'b10000
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: valid/ready byte pop port between the receiver and uart1.
//   dat   - head byte (first-word-fall-through, zero when empty)
//   valid - a byte is available
//   ready - consumer pops the head byte on valid & ready
// master: the receiver (byte source); slave: the consumer.
interface uart_rx_deser_if;
    import uart_pkg::*;

    logic [BYTE_W-1:0] dat;
    logic              valid;
    logic              ready;

    modport master (output dat, output valid, input ready);
    modport slave  (input dat, input valid, output ready);
endinterface

// File: rtl/uart_rx_deser_byte_fifo.sv
// byte_fifo: first-word-fall-through circular buffer.
//   clk, rst_n      - clock, async active-low reset
//   push, din       - write request and data
//   pop             - read request (ignored when empty)
//   dout            - head entry
//   full, empty     - occupancy flags
//   count           - entries held, 0..DEPTH
// A push while full is accepted only if a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || pop);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      count <= count + 1'b1;
            else if (!wr_en && rd_en) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 LSB-first serial receiver in front of the uart1 CSR.
//   clk_48_i     - system clock
//   rst_ni       - async active-low reset
//   rx_i         - raw serial line (idle high), asynchronous
//   pop          - uart_rx_deser_if.master byte pop port (dat/valid/ready)
//   irq_o        - level interrupt, follows pop.valid
//   count_o      - bytes buffered
//   frame_err_o  - sticky, stop bit sampled low
//   overrun_o    - sticky, byte dropped on a full buffer
//   clr_err_i    - pulse clears both sticky flags (a same-cycle set wins)
// Build option UART_RX_FIFO_EN: FIFO_DEPTH-entry byte_fifo; otherwise a single
// holding register.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 19_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk_48_i,
    input  logic                   rst_ni,
    input  logic                   rx_i,
    uart_rx_deser_if.master        pop,
    output logic                   irq_o,
    output logic [3:0]             count_o,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    input  logic                   clr_err_i
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    logic              rx_m, rx_s;
    rx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [BYTE_W-1:0] shreg;
    logic              bit_end, push, ferr_set, ovr_set;
    logic              valid_int;
    logic [BYTE_W-1:0] head;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk_48_i or negedge rst_ni) begin
        if (!rst_ni) {rx_m, rx_s} <= 2'b11;
        else         {rx_m, rx_s} <= {rx_i, rx_m};
    end

    assign bit_end  = cnt == CNT_W'(CLKS_PER_BIT - 1);
    // Push and frame-error decisions happen in the stop-bit sample cycle so
    // the buffer updates on that same edge.
    assign push     = (state == STOP) && bit_end && rx_s;
    assign ferr_set = (state == STOP) && bit_end && !rx_s;

    always_ff @(posedge clk_48_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == CNT_W'(HALF_BIT - 1)) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_s) state <= IDLE;
                    else begin
                        state <= DATA;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end else cnt <= cnt + 1'b1;
                DATA: if (bit_end) begin
                    shreg[idx] <= rx_s;
                    cnt        <= '0;
                    if (idx == 3'd7) state <= STOP;
                    else             idx   <= idx + 1'b1;
                end else cnt <= cnt + 1'b1;
                STOP: if (bit_end) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : WAIT_HI;
                end else cnt <= cnt + 1'b1;
                // A held-low line (break) must not re-trigger a frame.
                WAIT_HI: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_48_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (ferr_set)       frame_err_o <= 1'b1;
            else if (clr_err_i) frame_err_o <= 1'b0;
            if (ovr_set)        overrun_o   <= 1'b1;
            else if (clr_err_i) overrun_o   <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic                        full, empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk   (clk_48_i),
        .rst_n (rst_ni),
        .push  (push),
        .din   (shreg),
        .pop   (pop.ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    assign valid_int = !empty;
    assign count_o   = 4'(fifo_cnt);
    assign ovr_set   = push && full && !pop.ready;
`else
    logic [BYTE_W-1:0] hold_q;
    logic              hold_v;

    // Pop is applied first so a same-cycle push refills the register.
    always_ff @(posedge clk_48_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            hold_v <= 1'b0;
        end else begin
            if (hold_v && pop.ready) hold_v <= 1'b0;
            if (push && (!hold_v || pop.ready)) begin
                hold_q <= shreg;
                hold_v <= 1'b1;
            end
        end
    end

    assign head      = hold_q;
    assign valid_int = hold_v;
    assign count_o   = {3'b000, hold_v};
    assign ovr_set   = push && hold_v && !pop.ready;
`endif

    assign pop.valid = valid_int;
    assign pop.dat   = valid_int ? head : '0;
    assign irq_o     = valid_int;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser. Runs at 48 clocks per bit to keep the
// frame count cheap; latency expectations scale from the same formula.
module tb_uart_rx_deser;
    localparam int CLK_HZ  = 48_000_000;
    localparam int BAUD    = 1_000_000;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int HALF    = CPB / 2;
    localparam int EXP_LAT = 2 + HALF + 9 * CPB;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr = 1'b0;
    logic       irq;
    logic [3:0] count;
    logic       ferr, ovr;

    uart_rx_deser_if pop_if();

    uart_rx_deser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(8)) dut (
        .clk_48_i    (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .pop         (pop_if),
        .irq_o       (irq),
        .count_o     (count),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .clr_err_i   (clr)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         lat_meas;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input logic accept);
        if (accept) exp_q.push_back(b);
        send_frame(b, 1'b1);
        idle(4);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(pop_if.valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_vld"}, 32'(pop_if.valid), 32'd1);
            chk({tag, "_irq"}, 32'(irq), 32'd1);
            chk({tag, "_dat"}, 32'(pop_if.dat), 32'(e));
            pop_if.ready = 1'b1;
            @(negedge clk);
            pop_if.ready = 1'b0;
        end
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_vld"},   32'(pop_if.valid), 32'd0);
        chk({tag, "_dat"},   32'(pop_if.dat),   32'd0);
        chk({tag, "_irq"},   32'(irq),          32'd0);
        chk({tag, "_cnt"},   32'(count),        32'd0);
        chk({tag, "_ferr"},  32'(ferr),         32'd0);
        chk({tag, "_ovr"},   32'(ovr),          32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pop_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        idle(5);

        // 1: single byte, latency from start-bit falling edge, then pop.
        exp_q.push_back(8'h41);
        lat_meas = -1;
        fork
            send_frame(8'h41, 1'b1);
            begin
                for (int i = 1; i <= EXP_LAT + 40; i++) begin
                    @(negedge clk);
                    if (pop_if.valid) begin
                        lat_meas = i;
                        break;
                    end
                end
            end
        join
        chk("t1_latency",
            (lat_meas >= EXP_LAT - 2 && lat_meas <= EXP_LAT + 2) ? 32'(EXP_LAT) : 32'(lat_meas),
            32'(EXP_LAT));
        if (lat_meas < EXP_LAT - 2 || lat_meas > EXP_LAT + 2) lat_meas = EXP_LAT + 1;
        idle(2);
        chk("t1_cnt", 32'(count), 32'd1);
        pop_chk("t1_pop");
        chk("t1_cnt_after", 32'(count), 32'd0);

        // 2: short low pulse is rejected at mid start bit.
        rx = 1'b0;
        idle(HALF / 2);
        rx = 1'b1;
        idle(2 * CPB);
        chk("t2_vld",  32'(pop_if.valid), 32'd0);
        chk("t2_ferr", 32'(ferr), 32'd0);
        chk("t2_ovr",  32'(ovr), 32'd0);

        // 3: stop bit low -> frame error, byte discarded; clear it.
        send_frame(8'h55, 1'b0);
        idle(CPB);
        chk("t3_ferr", 32'(ferr), 32'd1);
        chk("t3_cnt",  32'(count), 32'd0);
        clr_pulse();
        chk("t3_ferr_clr", 32'(ferr), 32'd0);

        // 4: one byte more than the buffer holds -> overrun, first DEPTH kept.
        for (int i = 0; i <= DEPTH; i++) send_good(8'(8'h30 + i), i < DEPTH);
        chk("t4_cnt", 32'(count), 32'(DEPTH));
        chk("t4_ovr", 32'(ovr), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_chk("t4_pop");
        chk("t4_cnt_after", 32'(count), 32'd0);
        clr_pulse();
        chk("t4_ovr_clr", 32'(ovr), 32'd0);

        // 5: full buffer, pop lands on the push cycle -> byte accepted.
        for (int i = 0; i < DEPTH; i++) send_good(8'(8'h30 + i), 1'b1);
        chk("t5_full_cnt", 32'(count), 32'(DEPTH));
        fork
            send_frame(8'h39, 1'b1);
            begin
                repeat (lat_meas - 1) @(negedge clk);
                pop_chk("t5_edge_pop");
                exp_q.push_back(8'h39);
            end
        join
        idle(4);
        chk("t5_cnt", 32'(count), 32'(DEPTH));
        chk("t5_ovr", 32'(ovr), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_chk("t5_pop");
        chk("t5_cnt_after", 32'(count), 32'd0);

        // 6: reset mid-frame with a byte held and an error flagged.
        send_good(8'h5A, 1'b1);
        send_frame(8'h00, 1'b0);
        idle(CPB);
        rx = 1'b0;          // start of 0x7E
        idle(CPB);
        rx = 1'b0;          // bit0
        idle(CPB);
        rx = 1'b1;          // bit1
        idle(HALF);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_rst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3 * CPB);
        send_good(8'h12, 1'b1);
        send_good(8'h34, DEPTH > 1);
        chk("t6_cnt", 32'(count), (DEPTH > 1) ? 32'd2 : 32'd1);
        chk("t6_ovr", 32'(ovr),   (DEPTH > 1) ? 32'd0 : 32'd1);
        while (exp_q.size() > 0) pop_chk("t6_pop");
        chk("t6_cnt_after", 32'(count), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
